// File: rtl/div_iter_if.sv
// Request/result bundle between the execute stage and the iterative divider.
interface div_iter_if;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic        busy;
    logic        ready;
    logic [31:0] result_hi;
    logic [31:0] result_lo;

    modport master (
        output start, signed_div, opdata1, opdata2, annul,
        input  busy, ready, result_hi, result_lo
    );

    modport slave (
        input  start, signed_div, opdata1, opdata2, annul,
        output busy, ready, result_hi, result_lo
    );
endinterface

// File: rtl/div_iter.sv
// Iterative 32-bit radix-2 restoring divider for DIV/DIVU; remainder -> HI, quotient -> LO.
// Optional: define DIV_ZERO_FAST_EN to route a zero divisor through ZERO (3-cycle latency).
module div_iter (
    input  logic      clk,
    input  logic      resetn,
    div_iter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ZERO, S_ON, S_END} state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [64:0] r_sr;
    logic [31:0] r_divisor;
    logic [31:0] r_dividend;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div_zero;
    logic        r_busy;
    logic        r_ready;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_neg1;
    logic        w_neg2;
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic [33:0] w_trial;
    logic [64:0] w_step;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_neg1 = bus.signed_div & bus.opdata1[31];
    assign w_neg2 = bus.signed_div & bus.opdata2[31];
    assign w_mag1 = w_neg1 ? (32'd0 - bus.opdata1) : bus.opdata1;
    assign w_mag2 = w_neg2 ? (32'd0 - bus.opdata2) : bus.opdata2;

    // Trial subtract on the shifted upper bits; bit 64 is always zero between steps.
    assign w_trial = r_sr[64:31] - {2'b00, r_divisor};

    always_comb begin
        w_step = {r_sr[63:0], 1'b0};
        if (!w_trial[33]) begin
            w_step[64:32] = w_trial[32:0];
            w_step[0]     = 1'b1;
        end
    end

    assign w_quot = r_neg_q ? (32'd0 - r_sr[31:0])  : r_sr[31:0];
    assign w_rem  = r_neg_r ? (32'd0 - r_sr[63:32]) : r_sr[63:32];

    assign bus.busy      = r_busy;
    assign bus.ready     = r_ready;
    assign bus.result_hi = r_hi;
    assign bus.result_lo = r_lo;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_cnt      <= 6'd0;
            r_sr       <= 65'd0;
            r_divisor  <= 32'd0;
            r_dividend <= 32'd0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
        end else begin
            r_ready <= 1'b0;
            if (r_state != S_IDLE && bus.annul) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_cnt <= 6'd0;
                        if (bus.start && !bus.annul) begin
                            r_sr       <= {33'd0, w_mag1};
                            r_divisor  <= w_mag2;
                            r_dividend <= bus.opdata1;
                            r_neg_q    <= w_neg1 ^ w_neg2;
                            r_neg_r    <= w_neg1;
                            r_div_zero <= (bus.opdata2 == 32'd0);
                            r_busy     <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
                            r_state    <= (bus.opdata2 == 32'd0) ? S_ZERO : S_ON;
`else
                            r_state    <= S_ON;
`endif
                        end
                    end
                    S_ON: begin
                        r_sr  <= w_step;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'd31) begin
                            r_state <= S_END;
                        end
                    end
                    S_ZERO: begin
                        r_state <= S_END;
                    end
                    S_END: begin
                        // A zero divisor forces MIPS-style results regardless of sign handling.
                        if (r_div_zero) begin
                            r_hi <= r_dividend;
                            r_lo <= 32'hFFFF_FFFF;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter: latency, signed/unsigned results, zero divisor,
// annul, back-to-back issue and mid-operation reset.
module tb_div_iter;
    logic clk;
    logic resetn;
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 3;
`else
    localparam int ZLAT = 34;
`endif

    div_iter_if bus ();

    div_iter dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge (cycle 0); returns at the negedge of the ready cycle or after the bound.
    task automatic issue_and_wait(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                  output int lat, output int busy_cnt, output logic busy_at_rdy,
                                  output logic [31:0] hi, output logic [31:0] lo);
        bus.start      = 1'b1;
        bus.opdata1    = a;
        bus.opdata2    = b;
        bus.signed_div = sgn;
        lat = -1; busy_cnt = 0; busy_at_rdy = 1'bx; hi = 'x; lo = 'x;
        for (int k = 1; k <= 100 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start      = 1'b0;
                bus.opdata1    = ~a;
                bus.opdata2    = b ^ 32'h0000_5A5A;
                bus.signed_div = ~sgn;
            end
            if (bus.ready === 1'b1) begin
                lat = k; busy_at_rdy = bus.busy; hi = bus.result_hi; lo = bus.result_lo;
            end else if (bus.busy === 1'b1) begin
                busy_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
        n_checks++; if (bus.result_hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", bus.result_hi); end
        n_checks++; if (bus.result_lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", bus.result_lo); end
        resetn = 1'b1;
        @(negedge clk);
        $display("reset: busy=%b ready=%b hi=%h lo=%h", bus.busy, bus.ready, bus.result_hi, bus.result_lo);
    endtask

    task automatic test_divu();
        int lat, bc; logic br; logic [31:0] hi, lo;
        issue_and_wait(32'd100, 32'd7, 1'b0, lat, bc, br, hi, lo);
        $display("divu 100/7: hi=%h lo=%h ready_cycle=%0d busy_cycles=%0d", hi, lo, lat, bc);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL divu_latency: got %0d expected 34", lat); end
        n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL divu_quot: got %h expected %h", lo, 32'd14); end
        n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL divu_rem: got %h expected %h", hi, 32'd2); end
        n_checks++; if (bc !== 33) begin n_fail++; $display("FAIL divu_busy_cycles: got %0d expected 33", bc); end
        n_checks++; if (br !== 1'b0) begin n_fail++; $display("FAIL divu_busy_at_ready: got %b expected 0", br); end
        @(negedge clk);
        n_checks++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL divu_ready_pulse: got %b expected 0", bus.ready); end
        n_checks++; if (bus.result_lo !== 32'd14) begin n_fail++; $display("FAIL divu_hold: got %h expected %h", bus.result_lo, 32'd14); end
    endtask

    task automatic test_div_signed();
        logic [31:0] va [4] = '{32'hFFFF_FFF9, 32'd7,         32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] vb [4] = '{32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd2};
        logic        vs [4] = '{1'b1,          1'b1,          1'b1,          1'b0};
        logic [31:0] eq [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3,         32'h7FFF_FFFC};
        logic [31:0] er [4] = '{32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd1};
        int lat, bc; logic br; logic [31:0] hi, lo;
        for (int i = 0; i < 4; i++) begin
            issue_and_wait(va[i], vb[i], vs[i], lat, bc, br, hi, lo);
            $display("div%s %h/%h: hi=%h lo=%h ready_cycle=%0d", vs[i] ? "" : "u", va[i], vb[i], hi, lo, lat);
            n_checks++; if (lo !== eq[i]) begin n_fail++; $display("FAIL signed_quot[%0d]: got %h expected %h", i, lo, eq[i]); end
            n_checks++; if (hi !== er[i]) begin n_fail++; $display("FAIL signed_rem[%0d]: got %h expected %h", i, hi, er[i]); end
        end
    endtask

    task automatic test_overflow();
        int lat, bc; logic br; logic [31:0] hi, lo;
        issue_and_wait(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, bc, br, hi, lo);
        $display("div 80000000/ffffffff: hi=%h lo=%h ready_cycle=%0d", hi, lo, lat);
        n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_quot: got %h expected 80000000", lo); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL ovf_rem: got %h expected 0", hi); end
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL ovf_latency: got %0d expected 34", lat); end
    endtask

    task automatic test_div_zero();
        int lat, bc; logic br; logic [31:0] hi, lo;
        issue_and_wait(32'h1234_5678, 32'd0, 1'b0, lat, bc, br, hi, lo);
        $display("divu 12345678/0: hi=%h lo=%h ready_cycle=%0d", hi, lo, lat);
        n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL dz_rem: got %h expected 12345678", hi); end
        n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_quot: got %h expected ffffffff", lo); end
        n_checks++; if (lat !== ZLAT) begin n_fail++; $display("FAIL dz_latency: got %0d expected %0d", lat, ZLAT); end
        issue_and_wait(32'hFFFF_FFFB, 32'd0, 1'b1, lat, bc, br, hi, lo);
        $display("div fffffffb/0: hi=%h lo=%h ready_cycle=%0d", hi, lo, lat);
        n_checks++; if (hi !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL dz_signed_rem: got %h expected fffffffb", hi); end
        n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_signed_quot: got %h expected ffffffff", lo); end
    endtask

    task automatic test_annul();
        int lat, bc; logic br; logic [31:0] hi, lo;
        logic saw_ready;
        issue_and_wait(32'd1000, 32'd3, 1'b0, lat, bc, br, hi, lo);
        $display("divu 1000/3: hi=%h lo=%h ready_cycle=%0d", hi, lo, lat);
        n_checks++; if (lo !== 32'd333) begin n_fail++; $display("FAIL annul_prior_quot: got %h expected %h", lo, 32'd333); end
        bus.start = 1'b1; bus.opdata1 = 32'd50; bus.opdata2 = 32'd5; bus.signed_div = 1'b0;
        saw_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (bus.ready === 1'b1) saw_ready = 1'b1;
            if (k == 10) bus.annul = 1'b1;
        end
        @(negedge clk);
        bus.annul = 1'b0;
        $display("annul 50/5 in cycle 10: busy=%b hi=%h lo=%h", bus.busy, bus.result_hi, bus.result_lo);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL annul_busy: got %b expected 0", bus.busy); end
        n_checks++; if (saw_ready !== 1'b0 || bus.ready !== 1'b0) begin n_fail++; $display("FAIL annul_no_ready: got %b expected 0", saw_ready | bus.ready); end
        n_checks++; if (bus.result_hi !== 32'd1) begin n_fail++; $display("FAIL annul_hold_hi: got %h expected 1", bus.result_hi); end
        n_checks++; if (bus.result_lo !== 32'd333) begin n_fail++; $display("FAIL annul_hold_lo: got %h expected %h", bus.result_lo, 32'd333); end
        issue_and_wait(32'd81, 32'd9, 1'b0, lat, bc, br, hi, lo);
        $display("divu 81/9 after annul: hi=%h lo=%h ready_cycle=%0d", hi, lo, lat);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL post_annul_latency: got %0d expected 34", lat); end
        n_checks++; if (lo !== 32'd9 || hi !== 32'd0) begin n_fail++; $display("FAIL post_annul_result: got %h/%h expected 00000009/00000000", lo, hi); end
        bus.start = 1'b1; bus.annul = 1'b1; bus.opdata1 = 32'd40; bus.opdata2 = 32'd4;
        @(negedge clk);
        bus.start = 1'b0; bus.annul = 1'b0;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL annul_start_busy: got %b expected 0", bus.busy); end
        saw_ready = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) saw_ready = 1'b1;
        end
        $display("start+annul same cycle: ready_seen=%b lo=%h", saw_ready, bus.result_lo);
        n_checks++; if (saw_ready !== 1'b0) begin n_fail++; $display("FAIL annul_start_ready: got %b expected 0", saw_ready); end
        n_checks++; if (bus.result_lo !== 32'd9) begin n_fail++; $display("FAIL annul_start_lo: got %h expected 9", bus.result_lo); end
    endtask

    task automatic test_back_to_back();
        int r1 = -1, r2 = -1, n_rdy = 0;
        logic [31:0] hi1, lo1, hi2, lo2;
        logic busy1, busy35;
        bus.start = 1'b1; bus.opdata1 = 32'd100; bus.opdata2 = 32'd7; bus.signed_div = 1'b0;
        busy1 = 1'bx; busy35 = 1'bx;
        for (int k = 1; k <= 75; k++) begin
            @(negedge clk);
            if (k == 1) begin bus.opdata1 = 32'd1000; bus.opdata2 = 32'd3; end
            if (k == 60) bus.start = 1'b0;
            if (k == 35) busy35 = bus.busy;
            if (bus.ready === 1'b1) begin
                n_rdy++;
                if (r1 < 0) begin r1 = k; hi1 = bus.result_hi; lo1 = bus.result_lo; busy1 = bus.busy; end
                else if (r2 < 0) begin r2 = k; hi2 = bus.result_hi; lo2 = bus.result_lo; end
            end
        end
        $display("back-to-back: ready at %0d (%h/%h) and %0d (%h/%h)", r1, lo1, hi1, r2, lo2, hi2);
        n_checks++; if (r1 !== 34) begin n_fail++; $display("FAIL b2b_first_cycle: got %0d expected 34", r1); end
        n_checks++; if (lo1 !== 32'd14 || hi1 !== 32'd2) begin n_fail++; $display("FAIL b2b_first_result: got %h/%h expected 0000000e/00000002", lo1, hi1); end
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_34: got %b expected 0", busy1); end
        n_checks++; if (busy35 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_35: got %b expected 1", busy35); end
        n_checks++; if (r2 !== 68) begin n_fail++; $display("FAIL b2b_second_cycle: got %0d expected 68", r2); end
        n_checks++; if (lo2 !== 32'd333 || hi2 !== 32'd1) begin n_fail++; $display("FAIL b2b_second_result: got %h/%h expected 0000014d/00000001", lo2, hi2); end
        n_checks++; if (n_rdy !== 2) begin n_fail++; $display("FAIL b2b_ready_count: got %0d expected 2", n_rdy); end
    endtask

    task automatic test_reset_mid();
        logic saw_ready = 1'b0;
        bus.start = 1'b1; bus.opdata1 = 32'd100; bus.opdata2 = 32'd7; bus.signed_div = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (k == 20) resetn = 1'b0;
        end
        @(negedge clk);
        $display("reset in cycle 20: busy=%b ready=%b hi=%h lo=%h", bus.busy, bus.ready, bus.result_hi, bus.result_lo);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b expected 0", bus.ready); end
        n_checks++; if (bus.result_hi !== 32'd0 || bus.result_lo !== 32'd0) begin n_fail++; $display("FAIL midrst_results: got %h/%h expected 0/0", bus.result_hi, bus.result_lo); end
        resetn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) saw_ready = 1'b1;
        end
        n_checks++; if (saw_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_no_ready: got %b expected 0", saw_ready); end
    endtask

    initial begin
        bus.start = 1'b0; bus.signed_div = 1'b0; bus.annul = 1'b0;
        bus.opdata1 = 32'd0; bus.opdata2 = 32'd0;
        resetn = 1'b0;
        @(negedge clk);
        test_reset();
        test_divu();
        test_div_signed();
        test_overflow();
        test_div_zero();
        test_annul();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/div_iter.md
# div_iter

Iterative 32-bit radix-2 restoring divider for the execute stage of the MIPS core, serving DIV and DIVU. It sits directly upstream of the HI/LO register file: `result_hi` (remainder) and `result_lo` (quotient) connect to its `hi`/`lo` inputs, and `ready` drives its write enable. The divider holds operands internally, so the pipeline stalls on `busy` and can cancel an in-flight divide with `annul`.

## Interface

- No parameters; width fixed at 32.
- `clk` — input, 1 — rising-edge clock.
- `resetn` — input, 1 — reset, synchronous, active-low.
- `start` — input, 1 — request a divide; sampled only in IDLE.
- `signed_div` — input, 1 — 1 selects DIV (signed), 0 selects DIVU; latched with `start`.
- `opdata1` — input, 32 — dividend; latched with `start`.
- `opdata2` — input, 32 — divisor; latched with `start`.
- `annul` — input, 1 — abort the current operation (exception or flush).
- `busy` — output, 1 — high while state ≠ IDLE.
- `ready` — output, 1 — single-cycle pulse; results are valid and HI/LO should be written.
- `result_hi` — output, 32 — remainder; held until the next `ready`.
- `result_lo` — output, 32 — quotient; held until the next `ready`.

## Operation

- States: IDLE, ZERO, ON, END.
- **IDLE**
  - `start & ~annul`: latch operands and `signed_div`, then go to ON (or ZERO, see Configuration).
  - When signed, take the magnitude of each negative operand.
  - Clear the 6-bit iteration counter `cnt`.
- **ON**
  - 65-bit shift register holds {partial remainder, dividend}.
  - Each cycle: shift left 1, trial-subtract the divisor magnitude from the upper 33 bits, keep the result if non-negative, and shift the quotient bit in.
  - `cnt` increments; after `cnt == 31` the state becomes END.
- **ZERO**
  - One cycle, then END.
- **END**
  - Apply sign correction:
    - quotient negated iff signed and operand signs differ;
    - remainder negated iff signed and the dividend is negative.
  - Register the results, pulse `ready`, return to IDLE.
- **Divide by zero:** `result_hi` = original dividend, `result_lo` = 0xFFFFFFFF. This holds for both signed and unsigned, regardless of sign correction.
- **Signed overflow** (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0 (natural wrap). No trap.
- **`annul` in any non-IDLE state:**
  - next state is IDLE;
  - no `ready` pulse;
  - `result_hi`/`result_lo` unchanged.
- **`annul` and `start` in the same IDLE cycle:** `annul` wins; `start` is ignored.
- **`start` while busy:** ignored; operands are not re-latched.
- **Input stability:** operand inputs may change freely after the `start` cycle.
- **Reset:**
  - outputs: `busy` = 0, `ready` = 0, `result_hi` = 0, `result_lo` = 0;
  - internal: state = IDLE, `cnt` = 0.
  - Reset mid-operation aborts with no `ready`.

## Timing

- Normal divide, cycle 0 = `start` sampled:
  - ON occupies cycles 1–32;
  - END is cycle 33;
  - `ready` is high in cycle 34 only, with results valid from cycle 34 onward.
- `busy` is high in cycles 1–33 and low in cycle 34.
- A new `start` is accepted in cycle 34 (back-to-back issue).
- Divide-by-zero with the fast path: ZERO in cycle 1, END in cycle 2, `ready` in cycle 3.
- `ready` and all results are registered; there are no combinational paths from inputs to outputs.

## Configuration

- **`DIV_ZERO_FAST_EN` defined:** a zero divisor at `start` enters ZERO, giving 3-cycle latency.
- **Not defined:** a zero divisor runs the full ON sequence, giving 34-cycle latency. Result values are identical (dividend / 0xFFFFFFFF); END forces them.

## Test plan

- **DIVU** 100 / 7 → `ready` in cycle 34, `result_lo` = 14, `result_hi` = 2; `busy` high cycles 1–33.
- **DIV** −7 (0xFFFFFFF9) / 2 → `result_lo` = 0xFFFFFFFD (−3), `result_hi` = 0xFFFFFFFF (−1).
- **DIV** 0x80000000 / 0xFFFFFFFF → `result_lo` = 0x80000000, `result_hi` = 0.
- **Divide by zero:** DIVU 0x12345678 / 0 → `result_hi` = 0x12345678, `result_lo` = 0xFFFFFFFF.
  - `ready` in cycle 3 with `DIV_ZERO_FAST_EN`, cycle 34 without.
- **Annul:** start 50 / 5, assert `annul` in cycle 10 → `busy` low in cycle 11, no `ready`, results keep their prior values.
  - A new `start` in cycle 11 completes normally.
- **Back-to-back and mid-operation reset:**
  - `start` held high continuously → the second divide is accepted in cycle 34, with `ready` in cycles 34 and 68.
  - `resetn` low in cycle 20 → all outputs 0, no `ready`.
